// File: rtl/mac_lane_array.sv
// Broadcast-activation multi-lane MAC with per-lane weight memories.
// Optional per-lane saturating accumulate: define MAC_LANE_SAT_EN.
module mac_lane_array #(
  parameter int N_LANES = 4,
  parameter int I_W     = 8,
  parameter int W_W     = 8,
  parameter int W_D     = 4,
  parameter int RES_W   = 32,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_en,
  input  logic [N_LANES*W_W-1:0]   w_data,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [I_W-1:0]           i_data,
  input  logic                     i_signed,
  input  logic                     w_signed,
  input  logic [CNT_W-1:0]         acc_len,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_LANES*RES_W-1:0] res_data,
  output logic [N_LANES-1:0]       res_sat,
  output logic                     busy
);

  localparam int P_W = I_W + W_W;
  localparam int A_W = $clog2(W_D);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [N_LANES-1:0][W_D-1:0][W_W-1:0] w_q, w_d;
  logic [A_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [A_W-1:0]   rd_q, rd_d, rd_use;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] len_q, len_d, len_in;
  logic [N_LANES-1:0][RES_W-1:0] acc_q, acc_d;
  logic [N_LANES-1:0][RES_W-1:0] prod_q, prod_d;
  logic [N_LANES-1:0][RES_W-1:0] p_ext, acc_add;
  logic             prod_vld_q, prod_vld_d;
  logic [N_LANES-1:0] sat_q, sat_d, ovf;
`ifdef MAC_LANE_SAT_EN
  logic             psgn_q, psgn_d;
`endif

  logic             beat;
  logic             wr;
  logic             sgn_cur;
  logic signed [I_W:0] a_s;

  assign i_ready   = ((state_q == S_IDLE) & ~w_en)
                   | (state_q == S_RUN);
  assign beat      = i_valid & i_ready;
  assign wr        = (state_q == S_IDLE) & w_en;
  assign sgn_cur   = i_signed | w_signed;
  assign rd_use    = (state_q == S_IDLE) ? '0 : rd_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign len_in    = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign a_s       = {i_signed & i_data[I_W-1], i_data};

  assign res_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = acc_q;
  assign res_sat   = sat_q;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [W_W-1:0]          w_sel;
    logic signed [W_W:0]     b_s;
    logic signed [P_W-1:0]   p_tr;

    assign w_sel    = w_q[k][rd_use];
    assign b_s      = {w_signed & w_sel[W_W-1], w_sel};
    // low P_W bits of the sign-extended product are exact
    assign p_tr     = P_W'(a_s) * P_W'(b_s);
    assign p_ext[k] = sgn_cur ? RES_W'(p_tr)
                              : RES_W'($unsigned(p_tr));

`ifdef MAC_LANE_SAT_EN
    logic [RES_W:0]   sum;
    logic [RES_W-1:0] add_l;
    logic             ovf_l;

    assign sum = {psgn_q & acc_q[k][RES_W-1], acc_q[k]}
               + {psgn_q & prod_q[k][RES_W-1], prod_q[k]};

    always_comb begin
      add_l = sum[RES_W-1:0];
      ovf_l = 1'b0;
      if (psgn_q) begin
        if (sum[RES_W] != sum[RES_W-1]) begin
          ovf_l = 1'b1;
          add_l = sum[RES_W] ? {1'b1, {(RES_W-1){1'b0}}}
                             : {1'b0, {(RES_W-1){1'b1}}};
        end
      end else if (sum[RES_W]) begin
        ovf_l = 1'b1;
        add_l = '1;
      end
    end

    assign acc_add[k] = add_l;
    assign ovf[k]     = ovf_l;
`else
    assign acc_add[k] = acc_q[k] + prod_q[k];
    assign ovf[k]     = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    wr_ptr_d   = wr_ptr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    sat_d      = sat_q;
`ifdef MAC_LANE_SAT_EN
    psgn_d     = psgn_q;
`endif

    // drain the product registered on the previous beat
    if (prod_vld_q) begin
      acc_d = acc_add;
      sat_d = sat_q | ovf;
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr) begin
          for (int k = 0; k < N_LANES; k++) begin
            w_d[k][wr_ptr_q] = w_data[k*W_W +: W_W];
          end
          wr_ptr_d = wr_ptr_q + A_W'(1);
        end else if (beat) begin
          len_d      = len_in;
          acc_d      = '0;
          sat_d      = '0;
          cnt_d      = CNT_W'(1);
          rd_d       = A_W'(1);
          prod_d     = p_ext;
          prod_vld_d = 1'b1;
`ifdef MAC_LANE_SAT_EN
          psgn_d     = sgn_cur;
`endif
          state_d    = (len_in == CNT_W'(1)) ? S_FLUSH
                                             : S_RUN;
        end
      end
      S_RUN: begin
        if (beat) begin
          prod_d     = p_ext;
          prod_vld_d = 1'b1;
`ifdef MAC_LANE_SAT_EN
          psgn_d     = sgn_cur;
`endif
          cnt_d      = cnt_inc;
          rd_d       = rd_q + A_W'(1);
          if (cnt_inc == len_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      wr_ptr_q   <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      sat_q      <= '0;
`ifdef MAC_LANE_SAT_EN
      psgn_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      sat_q      <= sat_d;
`ifdef MAC_LANE_SAT_EN
      psgn_q     <= psgn_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: 32-bit and 16-bit result instances in lockstep.
// Expected sums come from a per-run arithmetic model of the lanes.
module tb_mac_lane_array;

  localparam int NL = 2;
  localparam int IW = 8;
  localparam int WW = 8;
  localparam int WD = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic w_en = 1'b0;
  logic i_valid = 1'b0;
  logic i_signed = 1'b0;
  logic w_signed = 1'b0;
  logic res_ready = 1'b0;
  logic [NL*WW-1:0] w_data = '0;
  logic [IW-1:0]    i_data = '0;
  logic [CW-1:0]    acc_len = '0;

  logic           rdy_a, val_a, busy_a;
  logic [NL*32-1:0] data_a;
  logic [NL-1:0]  sat_a;
  logic           rdy_b, val_b, busy_b;
  logic [NL*16-1:0] data_b;
  logic [NL-1:0]  sat_b;

  mac_lane_array #(
    .N_LANES(NL), .I_W(IW), .W_W(WW), .W_D(WD),
    .RES_W(32), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .w_en(w_en), .w_data(w_data),
    .i_valid(i_valid), .i_ready(rdy_a), .i_data(i_data),
    .i_signed(i_signed), .w_signed(w_signed),
    .acc_len(acc_len), .res_valid(val_a),
    .res_ready(res_ready), .res_data(data_a),
    .res_sat(sat_a), .busy(busy_a)
  );

  mac_lane_array #(
    .N_LANES(NL), .I_W(IW), .W_W(WW), .W_D(WD),
    .RES_W(16), .CNT_W(CW)
  ) u_dut16 (
    .clk(clk), .reset(reset), .w_en(w_en), .w_data(w_data),
    .i_valid(i_valid), .i_ready(rdy_b), .i_data(i_data),
    .i_signed(i_signed), .w_signed(w_signed),
    .acc_len(acc_len), .res_valid(val_b),
    .res_ready(res_ready), .res_data(data_b),
    .res_sat(sat_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] wm [NL][WD];
  int         wp;
  longint     acc32 [NL];
  longint     acc16 [NL];
  bit         s32 [NL];
  bit         s16 [NL];
  logic [NL*32-1:0] cap_a;
  logic [NL*16-1:0] cap_b;
  logic [NL-1:0]    cap_sb;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one accumulate step: wrap, or clamp to the signed/unsigned range
  function automatic longint madd(input longint acc, input longint p,
                                  input int r, input bit sg,
                                  input bit si, output bit so);
    longint lim;
    longint a;
    longint s;
    lim = longint'(1) << r;
    so  = si;
`ifdef MAC_LANE_SAT_EN
    a = acc;
    if (sg && a >= lim / 2) a = a - lim;
    s = a + p;
    if (sg) begin
      if (s > lim / 2 - 1) begin
        s = lim / 2 - 1;
        so = 1'b1;
      end else if (s < -(lim / 2)) begin
        s = -(lim / 2);
        so = 1'b1;
      end
    end else if (s > lim - 1) begin
      s = lim - 1;
      so = 1'b1;
    end
    return s & (lim - 1);
`else
    a = acc;
    s = a + p;
    return s & (lim - 1);
`endif
  endfunction

  task automatic write_w(input logic [7:0] d0, input logic [7:0] d1);
    w_en    = 1'b1;
    w_data  = {d1, d0};
    i_valid = 1'($urandom_range(0, 1));
    i_data  = 8'($urandom);
    #1;
    chk("wr_iready", {rdy_a, rdy_b}, 2'b00);
    @(negedge clk);
    w_en    = 1'b0;
    i_valid = 1'b0;
    wm[0][wp] = d0;
    wm[1][wp] = d1;
    wp = (wp + 1) % WD;
    #1;
    chk("wr_nobeat_busy", {busy_a, busy_b}, 2'b00);
  endtask

  task automatic run(input logic [7:0] alen, input bit isg,
                     input bit wsg, input int dval, input int hold);
    int len;
    bit sg;
    logic [7:0] d;
    longint ai, bi, p;
    logic [NL*32-1:0] ea;
    logic [NL*16-1:0] eb;
    logic [NL-1:0] esa, esb;
    len = (alen == 0) ? 1 : int'(alen);
    sg  = isg | wsg;
    for (int k = 0; k < NL; k++) begin
      acc32[k] = 0; acc16[k] = 0; s32[k] = 0; s16[k] = 0;
    end
    i_signed = isg;
    w_signed = wsg;
    acc_len  = alen;
    for (int n = 0; n < len; n++) begin
      if (n > 0) begin
        repeat ($urandom_range(0, 2)) begin
          i_valid = 1'b0;
          i_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      d = (dval < 0) ? 8'($urandom) : dval[7:0];
      i_valid = 1'b1;
      i_data  = d;
      #1;
      chk("beat_iready", {rdy_a, rdy_b}, 2'b11);
      ai = isg ? longint'($signed(d)) : longint'(d);
      for (int k = 0; k < NL; k++) begin
        bi = wsg ? longint'($signed(wm[k][n % WD]))
                 : longint'(wm[k][n % WD]);
        p = (ai * bi) & 64'hFFFF;
        if (sg && p >= 32768) p = p - 65536;
        acc32[k] = madd(acc32[k], p, 32, sg, s32[k], s32[k]);
        acc16[k] = madd(acc16[k], p, 16, sg, s16[k], s16[k]);
      end
      @(negedge clk);
      if (n == 0) acc_len = 8'($urandom);
    end
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    for (int k = 0; k < NL; k++) begin
      ea[k*32 +: 32] = acc32[k][31:0];
      eb[k*16 +: 16] = acc16[k][15:0];
      esa[k] = s32[k];
      esb[k] = s16[k];
    end
    #1;
    chk("flush_valid", {val_a, val_b}, 2'b00);
    chk("flush_busy", {busy_a, busy_b}, 2'b11);
    chk("flush_iready", {rdy_a, rdy_b}, 2'b00);
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      res_ready = (h == hold);
      i_valid   = 1'($urandom_range(0, 1));
      #1;
      chk("hold_valid", {val_a, val_b}, 2'b11);
      chk("hold_iready", {rdy_a, rdy_b}, 2'b00);
      chk("hold_data32", data_a, ea);
      chk("hold_data16", data_b, eb);
      chk("hold_sat32", sat_a, esa);
      chk("hold_sat16", sat_b, esb);
      if (h == 0) begin
        cap_a  = data_a;
        cap_b  = data_b;
        cap_sb = sat_b;
      end
      @(negedge clk);
      i_valid = 1'b0;
    end
    res_ready = 1'b0;
    #1;
    chk("post_iready", {rdy_a, rdy_b}, 2'b11);
    chk("post_valid", {val_a, val_b}, 2'b00);
    chk("post_busy", {busy_a, busy_b}, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NL; k++)
      for (int e = 0; e < WD; e++) wm[k][e] = '0;
    wp = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_iready", {rdy_a, rdy_b}, 2'b11);
    chk("rst_valid", {val_a, val_b}, 2'b00);
    chk("rst_busy", {busy_a, busy_b}, 2'b00);
    chk("rst_data32", data_a, '0);
    chk("rst_data16", data_b, '0);
    chk("rst_sat", {sat_a, sat_b}, '0);
    @(negedge clk);

    write_w(8'd1, 8'hFF);
    write_w(8'd2, 8'hFF);
    write_w(8'd3, 8'hFF);
    write_w(8'd4, 8'hFF);
    run(8'd4, 1'b0, 1'b1, 1, 0);
    chk("tp1_lane0", cap_a[31:0], 32'd10);
    chk("tp1_lane1", cap_a[63:32], 32'hFFFF_FFFC);

    run(8'd6, 1'b0, 1'b1, 1, 5);
    chk("tp2_wrap_lane0", cap_a[31:0], 32'd13);

    repeat (4) write_w(8'h80, 8'h80);
    run(8'd2, 1'b1, 1'b1, 8'h80, 1);
    chk("tp3_lane0", cap_a[31:0], 32'd32768);
    chk("tp3_lane1", cap_a[63:32], 32'd32768);

    repeat (4) write_w(8'd127, 8'd127);
    run(8'd3, 1'b1, 1'b1, 127, 2);
`ifdef MAC_LANE_SAT_EN
    chk("tp4_r16_lane0", cap_b[15:0], 16'h7FFF);
    chk("tp4_r16_sat", cap_sb, 2'b11);
`else
    chk("tp4_r16_lane0", cap_b[15:0], 16'hBD03);
    chk("tp4_r16_sat", cap_sb, 2'b00);
`endif

    acc_len  = 8'd4;
    i_signed = 1'b0;
    w_signed = 1'b0;
    i_valid  = 1'b1;
    i_data   = 8'd3;
    repeat (2) @(negedge clk);
    i_valid = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NL; k++)
      for (int e = 0; e < WD; e++) wm[k][e] = '0;
    wp = 0;
    repeat (4) begin
      #1;
      chk("midrst_valid", {val_a, val_b}, 2'b00);
      chk("midrst_busy", {busy_a, busy_b}, 2'b00);
      @(negedge clk);
    end
    run(8'd0, 1'b0, 1'b0, 5, 0);
    chk("midrst_zero_w", cap_a, '0);

    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 5))
        write_w(8'($urandom), 8'($urandom));
      run(8'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), -1, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
